mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_rr_arb2.sv | 20 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 128;

    // Bit positions of the two requesters in request/grant vectors
    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-way round-robin selector with one-hot grant
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] grant
);

    // A lone requester wins outright; on contention rr picks instruction (1) or data (0)
    always_comb begin
        grant = 2'b00;
        if (req[PORT_I] && req[PORT_D]) begin
            grant = rr ? (2'b01 << PORT_I) : (2'b01 << PORT_D);
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates instruction-fetch and data ports onto one memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t state_q;
    state_t state_d;
    logic   rr_q;
    logic [1:0] req_vec;
    logic [1:0] grant;
    logic   grant_en;
    logic   win_d;
    logic [ADDR_W-1:0] sel_addr;
    logic   sel_we;
    logic   sel_err;
    logic   lat_port_d;
    logic   lat_we;
    logic   lat_err;
    logic   resp;
    logic   rd_ok;

    assign req_vec[PORT_I] = i_req;
    assign req_vec[PORT_D] = d_req;

    rr_arb2 u_rr_arb2 (
        .req   (req_vec),
        .rr    (rr_q),
        .grant (grant)
    );

    // Requests only count in IDLE; the winner's fields are picked from its own port
    assign grant_en = (state_q == ST_IDLE) && (|grant);
    assign win_d    = grant[PORT_D];
    assign sel_addr = win_d ? d_addr : i_addr;
    assign sel_we   = win_d & d_we;
    assign sel_err  = 32'(sel_addr) >= 32'(DEPTH);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fixed IDLE -> ISSUE -> RESP -> IDLE walk once a request is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_en) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Latch the winning request, launch its strobe and steer rr away from the winner
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q       <= 1'b0;
            lat_port_d <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (grant_en) begin
                rr_q       <= win_d;
                lat_port_d <= win_d;
                lat_we     <= sel_we;
                lat_err    <= sel_err;
                mem_addr   <= sel_addr;
                mem_wdata  <= sel_we ? d_wdata : '0;
                mem_read   <= !sel_we && !sel_err;
                mem_write  <= sel_we && !sel_err;
            end
        end
    end

    assign resp  = (state_q == ST_RESP);
    assign rd_ok = resp && !lat_we && !lat_err;

    // Outputs: only the latched winner acks in RESP; read data passes through for good reads
    always_comb begin
        busy    = (state_q != ST_IDLE);
        i_ack   = resp && !lat_port_d;
        d_ack   = resp && lat_port_d;
        i_err   = resp && !lat_port_d && lat_err;
        d_err   = resp && lat_port_d && lat_err;
        i_rdata = (rd_ok && !lat_port_d) ? mem_rdata : '0;
        d_rdata = (rd_ok && lat_port_d) ? mem_rdata : '0;
    end

endmodule
